// File: rtl/ex_operand_stage.sv
// ID/EX operand stage: registers decoded ID fields, forwards from EX/MEM and MEM/WB, drives ALU operands.
// Latency: one cycle from ID capture to ALU_DATA1/ALU_DATA2/ALU_SELECT; forwarding and HAZARD_STALL are combinational.
// Backpressure: EXT_STALL holds the stage; a load-use hazard raises HAZARD_STALL and loads one bubble; FLUSH overrides both.
module ex_operand_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int SEL_W      = 5
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  ID_VALID,
  input  logic [XLEN-1:0]       ID_PC,
  input  logic [XLEN-1:0]       ID_RS1_DATA,
  input  logic [XLEN-1:0]       ID_RS2_DATA,
  input  logic [XLEN-1:0]       ID_IMM,
  input  logic [REG_ADDR_W-1:0] ID_RS1_ADDR,
  input  logic [REG_ADDR_W-1:0] ID_RS2_ADDR,
  input  logic [REG_ADDR_W-1:0] ID_RD_ADDR,
  input  logic [SEL_W-1:0]      ID_ALU_SELECT,
  input  logic                  ID_OP1_SEL,
  input  logic                  ID_OP2_SEL,
  input  logic                  ID_REG_WRITE,
  input  logic                  ID_MEM_READ,
  input  logic                  ID_MEM_WRITE,
  input  logic                  EXMEM_REG_WRITE,
  input  logic [REG_ADDR_W-1:0] EXMEM_RD_ADDR,
  input  logic [XLEN-1:0]       EXMEM_RESULT,
  input  logic                  MEMWB_REG_WRITE,
  input  logic [REG_ADDR_W-1:0] MEMWB_RD_ADDR,
  input  logic [XLEN-1:0]       MEMWB_RESULT,
  input  logic                  FLUSH,
  input  logic                  EXT_STALL,
  output logic [XLEN-1:0]       ALU_DATA1,
  output logic [XLEN-1:0]       ALU_DATA2,
  output logic [SEL_W-1:0]      ALU_SELECT,
  output logic [XLEN-1:0]       EX_PC,
  output logic [XLEN-1:0]       EX_STORE_DATA,
  output logic [REG_ADDR_W-1:0] EX_RD_ADDR,
  output logic                  EX_REG_WRITE,
  output logic                  EX_MEM_READ,
  output logic                  EX_MEM_WRITE,
  output logic                  EX_VALID,
  output logic                  HAZARD_STALL
);

  // Registered ID/EX fields
  logic [XLEN-1:0]       pc_q;
  logic [XLEN-1:0]       rs1_data_q;
  logic [XLEN-1:0]       rs2_data_q;
  logic [XLEN-1:0]       imm_q;
  logic [REG_ADDR_W-1:0] rs1_addr_q;
  logic [REG_ADDR_W-1:0] rs2_addr_q;
  logic [REG_ADDR_W-1:0] rd_addr_q;
  logic [SEL_W-1:0]      sel_q;
  logic                  op1_sel_q;
  logic                  op2_sel_q;
  logic                  reg_write_q;
  logic                  mem_read_q;
  logic                  mem_write_q;
  logic                  valid_q;

  // Combinational helpers
  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;
  logic            hazard;
  logic            rs1_uses_ld;
  logic            rs2_uses_ld;

  // Load-use detection against the load currently in EX; a flushed ID slot never stalls
  always_comb begin
    hazard      = 1'b0;
    rs1_uses_ld = (!ID_OP1_SEL) && (ID_RS1_ADDR == rd_addr_q);
    // stores need rs2 as store data even when the ALU takes the immediate
    rs2_uses_ld = (!ID_OP2_SEL || ID_MEM_WRITE) && (ID_RS2_ADDR == rd_addr_q);
    if (valid_q && mem_read_q && (rd_addr_q != '0) && ID_VALID && !FLUSH) begin
      hazard = rs1_uses_ld || rs2_uses_ld;
    end
  end

  // rs1 forwarding: EX/MEM is the younger producer so it wins; x0 never forwards
  always_comb begin
    rs1_fwd = rs1_data_q;
    if (EXMEM_REG_WRITE && (EXMEM_RD_ADDR != '0) && (EXMEM_RD_ADDR == rs1_addr_q)) begin
      rs1_fwd = EXMEM_RESULT;
    end else if (MEMWB_REG_WRITE && (MEMWB_RD_ADDR != '0) && (MEMWB_RD_ADDR == rs1_addr_q)) begin
      rs1_fwd = MEMWB_RESULT;
    end
  end

  // rs2 forwarding: same priority as rs1
  always_comb begin
    rs2_fwd = rs2_data_q;
    if (EXMEM_REG_WRITE && (EXMEM_RD_ADDR != '0) && (EXMEM_RD_ADDR == rs2_addr_q)) begin
      rs2_fwd = EXMEM_RESULT;
    end else if (MEMWB_REG_WRITE && (MEMWB_RD_ADDR != '0) && (MEMWB_RD_ADDR == rs2_addr_q)) begin
      rs2_fwd = MEMWB_RESULT;
    end
  end

  // Stage register: flush > external stall (hold) > hazard bubble > normal capture
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      pc_q        <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      rs1_addr_q  <= '0;
      rs2_addr_q  <= '0;
      rd_addr_q   <= '0;
      sel_q       <= '0;
      op1_sel_q   <= 1'b0;
      op2_sel_q   <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      valid_q     <= 1'b0;
    end else if (FLUSH || (!EXT_STALL && hazard)) begin
      // bubble: kill every control that could cause a side effect; datapath fields are don't-care
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      sel_q       <= '0;
      rd_addr_q   <= '0;
    end else if (!EXT_STALL) begin
      pc_q        <= ID_PC;
      rs1_data_q  <= ID_RS1_DATA;
      rs2_data_q  <= ID_RS2_DATA;
      imm_q       <= ID_IMM;
      rs1_addr_q  <= ID_RS1_ADDR;
      rs2_addr_q  <= ID_RS2_ADDR;
      rd_addr_q   <= ID_RD_ADDR;
      sel_q       <= ID_ALU_SELECT;
      op1_sel_q   <= ID_OP1_SEL;
      op2_sel_q   <= ID_OP2_SEL;
      reg_write_q <= ID_REG_WRITE;
      mem_read_q  <= ID_MEM_READ;
      mem_write_q <= ID_MEM_WRITE;
      valid_q     <= ID_VALID;
    end
  end

  // Operand muxing and output drive
  always_comb begin
    ALU_DATA1     = op1_sel_q ? pc_q : rs1_fwd;
    ALU_DATA2     = op2_sel_q ? imm_q : rs2_fwd;
    EX_STORE_DATA = rs2_fwd;
    ALU_SELECT    = sel_q;
    EX_PC         = pc_q;
    EX_RD_ADDR    = rd_addr_q;
    EX_REG_WRITE  = reg_write_q;
    EX_MEM_READ   = mem_read_q;
    EX_MEM_WRITE  = mem_write_q;
    EX_VALID      = valid_q;
    HAZARD_STALL  = hazard;
  end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Scoreboard bench for ex_operand_stage: expected EX contents queued at drive time, compared after each edge.
// Inputs change and outputs are sampled on the falling edge, away from the active rising edge.
// Combinational outputs (forwarding, HAZARD_STALL) are checked directly #1 after inputs change.
module tb_ex_operand_stage;

  logic        CLK;
  logic        RESET;
  logic        ID_VALID;
  logic [31:0] ID_PC, ID_RS1_DATA, ID_RS2_DATA, ID_IMM;
  logic [4:0]  ID_RS1_ADDR, ID_RS2_ADDR, ID_RD_ADDR, ID_ALU_SELECT;
  logic        ID_OP1_SEL, ID_OP2_SEL, ID_REG_WRITE, ID_MEM_READ, ID_MEM_WRITE;
  logic        EXMEM_REG_WRITE;
  logic [4:0]  EXMEM_RD_ADDR;
  logic [31:0] EXMEM_RESULT;
  logic        MEMWB_REG_WRITE;
  logic [4:0]  MEMWB_RD_ADDR;
  logic [31:0] MEMWB_RESULT;
  logic        FLUSH, EXT_STALL;
  logic [31:0] ALU_DATA1, ALU_DATA2, EX_PC, EX_STORE_DATA;
  logic [4:0]  ALU_SELECT, EX_RD_ADDR;
  logic        EX_REG_WRITE, EX_MEM_READ, EX_MEM_WRITE, EX_VALID, HAZARD_STALL;

  ex_operand_stage dut (
    .CLK(CLK), .RESET(RESET), .ID_VALID(ID_VALID), .ID_PC(ID_PC),
    .ID_RS1_DATA(ID_RS1_DATA), .ID_RS2_DATA(ID_RS2_DATA), .ID_IMM(ID_IMM),
    .ID_RS1_ADDR(ID_RS1_ADDR), .ID_RS2_ADDR(ID_RS2_ADDR), .ID_RD_ADDR(ID_RD_ADDR),
    .ID_ALU_SELECT(ID_ALU_SELECT), .ID_OP1_SEL(ID_OP1_SEL), .ID_OP2_SEL(ID_OP2_SEL),
    .ID_REG_WRITE(ID_REG_WRITE), .ID_MEM_READ(ID_MEM_READ), .ID_MEM_WRITE(ID_MEM_WRITE),
    .EXMEM_REG_WRITE(EXMEM_REG_WRITE), .EXMEM_RD_ADDR(EXMEM_RD_ADDR), .EXMEM_RESULT(EXMEM_RESULT),
    .MEMWB_REG_WRITE(MEMWB_REG_WRITE), .MEMWB_RD_ADDR(MEMWB_RD_ADDR), .MEMWB_RESULT(MEMWB_RESULT),
    .FLUSH(FLUSH), .EXT_STALL(EXT_STALL),
    .ALU_DATA1(ALU_DATA1), .ALU_DATA2(ALU_DATA2), .ALU_SELECT(ALU_SELECT), .EX_PC(EX_PC),
    .EX_STORE_DATA(EX_STORE_DATA), .EX_RD_ADDR(EX_RD_ADDR), .EX_REG_WRITE(EX_REG_WRITE),
    .EX_MEM_READ(EX_MEM_READ), .EX_MEM_WRITE(EX_MEM_WRITE), .EX_VALID(EX_VALID),
    .HAZARD_STALL(HAZARD_STALL)
  );

  typedef struct {
    logic        valid;
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1a, rs2a, rd, sel;
    logic        op1, op2, rw, mr, mw;
  } id_t;

  typedef struct {
    logic        bubble;
    logic        valid, rw, mr, mw;
    logic [4:0]  rd, sel;
    logic [31:0] pc, d1, d2, st;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic id_t mk(input logic valid, input logic [31:0] pc,
                             input logic [4:0] rs1a, input logic [31:0] rs1d,
                             input logic [4:0] rs2a, input logic [31:0] rs2d,
                             input logic [31:0] imm, input logic [4:0] rd, input logic [4:0] sel,
                             input logic op1, input logic op2,
                             input logic rw, input logic mr, input logic mw);
    id_t v;
    v.valid = valid; v.pc = pc; v.rs1a = rs1a; v.rs1d = rs1d; v.rs2a = rs2a; v.rs2d = rs2d;
    v.imm = imm; v.rd = rd; v.sel = sel; v.op1 = op1; v.op2 = op2;
    v.rw = rw; v.mr = mr; v.mw = mw;
    return v;
  endfunction

  // expected EX contents for a captured instruction with no forwarding active
  function automatic exp_t model(input id_t v);
    exp_t e;
    e.bubble = 1'b0;
    e.valid = v.valid; e.rw = v.rw; e.mr = v.mr; e.mw = v.mw;
    e.rd = v.rd; e.sel = v.sel; e.pc = v.pc;
    e.d1 = v.op1 ? v.pc : v.rs1d;
    e.d2 = v.op2 ? v.imm : v.rs2d;
    e.st = v.rs2d;
    return e;
  endfunction

  function automatic exp_t bubble_exp();
    exp_t e;
    e.bubble = 1'b1;
    e.valid = 1'b0; e.rw = 1'b0; e.mr = 1'b0; e.mw = 1'b0;
    e.rd = '0; e.sel = '0; e.pc = '0; e.d1 = '0; e.d2 = '0; e.st = '0;
    return e;
  endfunction

  task automatic set_id(input id_t v);
    ID_VALID = v.valid; ID_PC = v.pc; ID_RS1_DATA = v.rs1d; ID_RS2_DATA = v.rs2d;
    ID_IMM = v.imm; ID_RS1_ADDR = v.rs1a; ID_RS2_ADDR = v.rs2a; ID_RD_ADDR = v.rd;
    ID_ALU_SELECT = v.sel; ID_OP1_SEL = v.op1; ID_OP2_SEL = v.op2;
    ID_REG_WRITE = v.rw; ID_MEM_READ = v.mr; ID_MEM_WRITE = v.mw;
  endtask

  task automatic clear_fwd();
    EXMEM_REG_WRITE = 1'b0; EXMEM_RD_ADDR = '0; EXMEM_RESULT = '0;
    MEMWB_REG_WRITE = 1'b0; MEMWB_RD_ADDR = '0; MEMWB_RESULT = '0;
  endtask

  // advance one edge, then pop the oldest expectation and compare the EX outputs
  task automatic step_check();
    exp_t e;
    @(posedge CLK);
    @(negedge CLK);
    chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("ex_valid", 32'(EX_VALID), 32'(e.valid));
      chk("ex_reg_write", 32'(EX_REG_WRITE), 32'(e.rw));
      chk("ex_mem_read", 32'(EX_MEM_READ), 32'(e.mr));
      chk("ex_mem_write", 32'(EX_MEM_WRITE), 32'(e.mw));
      chk("ex_rd_addr", 32'(EX_RD_ADDR), 32'(e.rd));
      chk("alu_select", 32'(ALU_SELECT), 32'(e.sel));
      if (!e.bubble) begin
        chk("ex_pc", EX_PC, e.pc);
        chk("alu_data1", ALU_DATA1, e.d1);
        chk("alu_data2", ALU_DATA2, e.d2);
        chk("store_data", EX_STORE_DATA, e.st);
      end
    end
  endtask

  id_t  p, add3, f, lw5, use5, a, v;
  exp_t ea;

  initial begin
    RESET = 1'b0; FLUSH = 1'b0; EXT_STALL = 1'b0;
    clear_fwd();
    set_id(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(negedge CLK);
    RESET = 1'b1;

    // 1. fill EX, then assert reset between edges and expect an immediate clear
    p = mk(1, 32'h40, 5'd1, 32'h123, 5'd2, 32'h456, 32'h9, 5'd6, 5'd2, 0, 0, 1, 0, 0);
    set_id(p); sb.push_back(model(p));
    step_check();
    #2 RESET = 1'b0;
    #1;
    chk("rst_ex_valid", 32'(EX_VALID), 32'd0);
    chk("rst_alu_data1", ALU_DATA1, 32'd0);
    chk("rst_alu_data2", ALU_DATA2, 32'd0);
    chk("rst_rd_addr", 32'(EX_RD_ADDR), 32'd0);
    chk("rst_reg_write", 32'(EX_REG_WRITE), 32'd0);
    chk("rst_pc", EX_PC, 32'd0);
    chk("rst_hazard", 32'(HAZARD_STALL), 32'd0);
    @(negedge CLK);
    RESET = 1'b1;
    add3 = mk(1, 32'h44, 5'd1, 32'd5, 5'd2, 32'd7, 32'h0, 5'd3, 5'd0, 0, 0, 1, 0, 0);
    set_id(add3); sb.push_back(model(add3));
    step_check();

    // 2. forwarding priority on rs1/rs2, with EX frozen so only the bypass inputs move
    f = mk(1, 32'h48, 5'd4, 32'h1111, 5'd6, 32'h22, 32'h33, 5'd7, 5'd1, 0, 1, 1, 0, 0);
    set_id(f); sb.push_back(model(f));
    step_check();
    EXT_STALL = 1'b1;
    EXMEM_REG_WRITE = 1'b1; EXMEM_RD_ADDR = 5'd4; EXMEM_RESULT = 32'hAAAA;
    MEMWB_REG_WRITE = 1'b1; MEMWB_RD_ADDR = 5'd4; MEMWB_RESULT = 32'hBBBB;
    #1;
    chk("fwd_exmem_wins", ALU_DATA1, 32'hAAAA);
    chk("fwd_imm_d2", ALU_DATA2, 32'h33);
    chk("fwd_store_nomatch", EX_STORE_DATA, 32'h22);
    EXMEM_REG_WRITE = 1'b0;
    #1;
    chk("fwd_memwb", ALU_DATA1, 32'hBBBB);
    EXMEM_REG_WRITE = 1'b1; EXMEM_RD_ADDR = 5'd0; MEMWB_RD_ADDR = 5'd0;
    #1;
    chk("fwd_x0_never", ALU_DATA1, 32'h1111);
    MEMWB_RD_ADDR = 5'd6; MEMWB_RESULT = 32'hCCCC;
    #1;
    chk("fwd_rs2_store", EX_STORE_DATA, 32'hCCCC);
    chk("fwd_rs2_imm_sel", ALU_DATA2, 32'h33);
    clear_fwd();
    @(negedge CLK);
    EXT_STALL = 1'b0;

    // 3. load-use: one bubble, then the dependent add picks up the loaded value from MEM/WB
    lw5 = mk(1, 32'h50, 5'd1, 32'h1000, 5'd0, 32'h0, 32'h4, 5'd5, 5'd0, 0, 1, 1, 1, 0);
    set_id(lw5); sb.push_back(model(lw5));
    step_check();
    use5 = mk(1, 32'h54, 5'd1, 32'd10, 5'd5, 32'd99, 32'h0, 5'd8, 5'd0, 0, 0, 1, 0, 0);
    set_id(use5);
    #1 chk("lu_stall", 32'(HAZARD_STALL), 32'd1);
    sb.push_back(bubble_exp());
    step_check();
    #1 chk("lu_stall_drops", 32'(HAZARD_STALL), 32'd0);
    MEMWB_REG_WRITE = 1'b1; MEMWB_RD_ADDR = 5'd5; MEMWB_RESULT = 32'h5555;
    ea = model(use5); ea.d2 = 32'h5555; ea.st = 32'h5555;
    sb.push_back(ea);
    step_check();
    clear_fwd();

    // 4. immediate form does not depend on rs2; a store does
    set_id(lw5); sb.push_back(model(lw5));
    step_check();
    v = mk(1, 32'h58, 5'd1, 32'd1, 5'd5, 32'd2, 32'h10, 5'd9, 5'd0, 0, 1, 1, 0, 0);
    set_id(v);
    #1 chk("lu_addi_no_stall", 32'(HAZARD_STALL), 32'd0);
    v = mk(1, 32'h58, 5'd1, 32'd1, 5'd5, 32'd2, 32'h10, 5'd0, 5'd0, 0, 1, 0, 0, 1);
    set_id(v);
    #1 chk("lu_sw_stall", 32'(HAZARD_STALL), 32'd1);
    ID_VALID = 1'b0;
    #1 chk("lu_id_invalid", 32'(HAZARD_STALL), 32'd0);
    v = mk(1, 32'h58, 5'd5, 32'd1, 5'd2, 32'd2, 32'h10, 5'd9, 5'd0, 1, 0, 1, 0, 0);
    set_id(v);
    #1 chk("lu_op1_pc", 32'(HAZARD_STALL), 32'd0);

    // 5. external stall holds EX while ID churns; flush beats the stall
    a = mk(1, 32'h200, 5'd1, 32'h31, 5'd2, 32'h32, 32'h0, 5'd9, 5'd3, 0, 0, 1, 0, 0);
    set_id(a); sb.push_back(model(a));
    step_check();
    EXT_STALL = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_id(mk(1, $urandom, 5'(i + 10), $urandom, 5'(i + 20), $urandom, $urandom,
                5'(i + 11), 5'(i + 1), 0, 0, 1, 1, 1));
      sb.push_back(model(a));
      step_check();
    end
    FLUSH = 1'b1;
    sb.push_back(bubble_exp());
    step_check();
    FLUSH = 1'b0; EXT_STALL = 1'b0;

    // 6. flush suppresses a load-use stall; PC operand ignores rs1 forwarding
    set_id(lw5); sb.push_back(model(lw5));
    step_check();
    set_id(use5);
    #1 chk("fl_hazard_present", 32'(HAZARD_STALL), 32'd1);
    FLUSH = 1'b1;
    #1 chk("fl_hazard_masked", 32'(HAZARD_STALL), 32'd0);
    sb.push_back(bubble_exp());
    step_check();
    FLUSH = 1'b0;
    v = mk(1, 32'h100, 5'd4, 32'h44, 5'd2, 32'h77, 32'h0, 5'd10, 5'd0, 1, 0, 1, 0, 0);
    set_id(v); sb.push_back(model(v));
    step_check();
    EXT_STALL = 1'b1;
    EXMEM_REG_WRITE = 1'b1; EXMEM_RD_ADDR = 5'd4; EXMEM_RESULT = 32'hAAAA;
    #1;
    chk("pc_op1_over_fwd", ALU_DATA1, 32'h100);
    chk("pc_op1_d2", ALU_DATA2, 32'h77);
    clear_fwd();
    EXT_STALL = 1'b0;

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
